// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage load/store unit: big-endian lane steering, req/ack bus
// transaction with timeout, and sign/zero-extended load responses.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        wd_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              rsp_valid_o,
  output logic [4:0]        rsp_wd_o,
  output logic              rsp_wreg_o,
  output logic [DATA_W-1:0] rsp_wdata_o,
  output logic [2:0]        rsp_exc_o,
  output logic              stallreq_o
);

  localparam int NB = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [7:0] TERM = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [4:0]        wd_q;
  logic [7:0]        cnt;
  logic [2:0]        exc_q;
  logic [3:0]        size_q;
  logic              load_q, sgn_q;

  logic [3:0] size_in, size_m1;
  logic       legal_in, misal_in, accept;
  logic [OFF_W-1:0] off_q;
  logic [NB-1:0]    sel;
  logic [DATA_W-1:0] wdata_rep, shifted, load_ext;
  logic             fill;
  int               shamt;

  // Access size in bytes; zero marks an op this bus width cannot perform.
  always_comb begin
    size_in = 4'd0;
    case (op_i)
      4'h0, 4'h1, 4'h8: size_in = 4'd1;
      4'h2, 4'h3, 4'h9: size_in = 4'd2;
      4'h4, 4'hA:       size_in = 4'd4;
      4'h5:             size_in = (DATA_W == 64) ? 4'd4 : 4'd0;
      4'h6, 4'hB:       size_in = (DATA_W == 64) ? 4'd8 : 4'd0;
      default:          size_in = 4'd0;
    endcase
  end

  assign size_m1  = size_in - 4'd1;
  assign legal_in = (size_in != 4'd0);
  assign misal_in = |(addr_i[2:0] & size_m1[2:0]);
  assign accept   = req_valid_i && (state == IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (legal_in && !misal_in) ? BUS : RESP;
      BUS:     if (bus_ack_i || cnt == TERM) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wd_q    <= '0;
      cnt     <= '0;
      exc_q   <= '0;
      size_q  <= '0;
      load_q  <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            wd_q    <= wd_i;
            size_q  <= size_in;
            load_q  <= ~op_i[3];
            sgn_q   <= (op_i == 4'h0) || (op_i == 4'h2) || (op_i == 4'h4);
            exc_q   <= !legal_in ? 3'd5 : (misal_in ? (op_i[3] ? 3'd2 : 3'd1) : 3'd0);
          end
        end
        BUS: begin
          cnt <= cnt + 8'd1;
          if (bus_ack_i) begin
            rdata_q <= bus_rdata_i;
            exc_q   <= bus_err_i ? 3'd3 : 3'd0;
          end else if (cnt == TERM) begin
            exc_q <= 3'd4;
          end
        end
        RESP:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  assign off_q = addr_q[OFF_W-1:0];

  // Byte at offset k lives in lane NB-1-k; the stored value repeats every size_q lanes
  // so its most significant byte lands on the lowest address.
  always_comb begin
    sel       = '0;
    wdata_rep = '0;
    for (int i = 0; i < NB; i++) begin
      if (i <= NB - 1 - int'(off_q) && i >= NB - int'(off_q) - int'(size_q))
        sel[i] = 1'b1;
      wdata_rep[8*i +: 8] = wdata_q[8*(i & (int'(size_q) - 1)) +: 8];
    end
  end

  always_comb begin
    shamt = NB - int'(off_q) - int'(size_q);
    if (shamt < 0) shamt = 0;
    shifted = rdata_q >> (8 * shamt);
    case (size_q)
      4'd1:    fill = sgn_q & shifted[7];
      4'd2:    fill = sgn_q & shifted[15];
      4'd4:    fill = sgn_q & shifted[31];
      default: fill = 1'b0;
    endcase
    load_ext = '0;
    for (int i = 0; i < DATA_W; i++)
      load_ext[i] = (i < 8 * int'(size_q)) ? shifted[i] : fill;
  end

  assign req_ready_o = (state == IDLE);
  assign stallreq_o  = (state != IDLE);
  assign bus_req_o   = (state == BUS);
  assign bus_we_o    = bus_req_o & ~load_q;
  assign bus_addr_o  = bus_req_o ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus_sel_o   = bus_req_o ? sel : '0;
  assign bus_wdata_o = bus_req_o ? wdata_rep : '0;
  assign rsp_valid_o = (state == RESP);
  assign rsp_wd_o    = wd_q;
  assign rsp_wreg_o  = rsp_valid_o && load_q && (exc_q == 3'd0);
  assign rsp_wdata_o = rsp_wreg_o ? load_ext : '0;
  assign rsp_exc_o   = rsp_valid_o ? exc_q : 3'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit/TIMEOUT=4 and a 64-bit/TIMEOUT=15 instance
// driven by directed and random accesses, checked against a byte-address model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  logic reqValid;
  logic [3:0] op;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;
  logic [4:0] wd;
  logic ack, err;
  int which;

  int checks = 0;
  int errors = 0;

  logic ready32, busReq32, we32, rspValid32, wreg32, stall32;
  logic [31:0] busAddr32, busWdata32, rspData32;
  logic [3:0] sel32;
  logic [4:0] rspWd32;
  logic [2:0] exc32;

  logic ready64, busReq64, we64, rspValid64, wreg64, stall64;
  logic [31:0] busAddr64;
  logic [63:0] busWdata64, rspData64;
  logic [7:0] sel64;
  logic [4:0] rspWd64;
  logic [2:0] exc64;

  logic obsReady, obsBusReq, obsWe, obsRspValid, obsWreg, obsStall;
  logic [63:0] obsBusAddr, obsBusWdata, obsRspData, obsSel;
  logic [4:0] obsRspWd;
  logic [2:0] obsExc;

  logic [63:0] lastSel, lastBusAddr, lastWdata, lastRspData;
  logic lastWe, lastWreg;
  logic [2:0] lastExc;
  int lastBusCycles, lastStall, lastRspCycle;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid && which == 0), .req_ready_o(ready32),
    .op_i(op), .addr_i(addr), .wdata_i(wdata[31:0]), .wd_i(wd),
    .bus_req_o(busReq32), .bus_we_o(we32), .bus_addr_o(busAddr32),
    .bus_sel_o(sel32), .bus_wdata_o(busWdata32),
    .bus_ack_i(ack), .bus_err_i(err), .bus_rdata_i(rdata[31:0]),
    .rsp_valid_o(rspValid32), .rsp_wd_o(rspWd32), .rsp_wreg_o(wreg32),
    .rsp_wdata_o(rspData32), .rsp_exc_o(exc32), .stallreq_o(stall32)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(15)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid && which == 1), .req_ready_o(ready64),
    .op_i(op), .addr_i(addr), .wdata_i(wdata), .wd_i(wd),
    .bus_req_o(busReq64), .bus_we_o(we64), .bus_addr_o(busAddr64),
    .bus_sel_o(sel64), .bus_wdata_o(busWdata64),
    .bus_ack_i(ack), .bus_err_i(err), .bus_rdata_i(rdata),
    .rsp_valid_o(rspValid64), .rsp_wd_o(rspWd64), .rsp_wreg_o(wreg64),
    .rsp_wdata_o(rspData64), .rsp_exc_o(exc64), .stallreq_o(stall64)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (which == 1) begin
      obsReady = ready64; obsBusReq = busReq64; obsWe = we64; obsRspValid = rspValid64;
      obsWreg = wreg64; obsStall = stall64; obsBusAddr = 64'(busAddr64);
      obsBusWdata = busWdata64; obsRspData = rspData64; obsSel = 64'(sel64);
      obsRspWd = rspWd64; obsExc = exc64;
    end else begin
      obsReady = ready32; obsBusReq = busReq32; obsWe = we32; obsRspValid = rspValid32;
      obsWreg = wreg32; obsStall = stall32; obsBusAddr = 64'(busAddr32);
      obsBusWdata = 64'(busWdata32); obsRspData = 64'(rspData32); obsSel = 64'(sel32);
      obsRspWd = rspWd32; obsExc = exc32;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One access from request to response; expectations come from per-byte addresses.
  task automatic applyStimulus(input int dutSel, input logic [3:0] opIn, input logic [31:0] addrIn,
                               input logic [63:0] wdataIn, input logic [4:0] wdIn,
                               input int ackAt, input logic errIn, input logic [63:0] rdataIn);
    int nb, tmo, size, k, lane, expBus, expRsp, busCnt, stallCnt, cyc;
    logic isLoad, isSigned, gotRsp;
    logic [2:0] expExc;
    logic [63:0] expSel, expW, laneMask, val, dataMask, expData;
    nb = (dutSel == 1) ? 8 : 4;
    tmo = (dutSel == 1) ? 15 : 4;
    dataMask = (dutSel == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (opIn)
      4'h0, 4'h1, 4'h8: size = 1;
      4'h2, 4'h3, 4'h9: size = 2;
      4'h4, 4'hA:       size = 4;
      4'h5:             size = (nb == 8) ? 4 : 0;
      4'h6, 4'hB:       size = (nb == 8) ? 8 : 0;
      default:          size = 0;
    endcase
    isLoad = (opIn < 4'h8);
    isSigned = opIn inside {4'h0, 4'h2, 4'h4};
    k = int'(addrIn % 32'(nb));
    expSel = '0; expW = '0; laneMask = '0; val = '0; expBus = 0;
    if (size == 0) begin
      expExc = 3'd5;
    end else if (addrIn % 32'(size) != 0) begin
      expExc = isLoad ? 3'd1 : 3'd2;
    end else begin
      for (int b = 0; b < size; b++) begin
        lane = nb - 1 - (k + b);
        expSel[lane] = 1'b1;
        laneMask |= 64'hFF << (8 * lane);
        expW |= ((wdataIn >> (8 * (size - 1 - b))) & 64'hFF) << (8 * lane);
        val = (val << 8) | ((rdataIn >> (8 * lane)) & 64'hFF);
      end
      if (isSigned && val[8*size-1]) val = val - (64'd1 << (8 * size));
      if (ackAt >= 1 && ackAt <= tmo) begin
        expBus = ackAt; expExc = errIn ? 3'd3 : 3'd0;
      end else begin
        expBus = tmo; expExc = 3'd4;
      end
    end
    expData = (isLoad && expExc == 3'd0) ? (val & dataMask) : 64'd0;
    expRsp = expBus + 1;
    lastSel = '0; lastBusAddr = '0; lastWdata = '0; lastWe = 1'b0;
    lastRspData = '0; lastWreg = 1'b0; lastExc = '0; lastRspCycle = 0;

    @(negedge clk);
    which = dutSel; op = opIn; addr = addrIn; wdata = wdataIn; wd = wdIn; reqValid = 1'b1;
    #1 checkOutput("req_ready", 64'(obsReady), 64'd1);
    @(negedge clk);
    reqValid = 1'b0; op = 4'($urandom); addr = $urandom; wdata = {$urandom, $urandom}; wd = 5'($urandom);
    busCnt = 0; stallCnt = 0; gotRsp = 1'b0; cyc = 1;
    while (!gotRsp && cyc <= 40) begin
      if (obsStall) stallCnt++;
      if (obsBusReq) begin
        busCnt++;
        checkOutput("bus_addr", obsBusAddr, 64'(addrIn - 32'(k)));
        checkOutput("bus_sel", obsSel, expSel);
        checkOutput("bus_we", 64'(obsWe), 64'(!isLoad));
        if (!isLoad) checkOutput("bus_wdata", obsBusWdata & laneMask, expW);
        if (busCnt == 1) begin
          lastSel = obsSel; lastBusAddr = obsBusAddr; lastWdata = obsBusWdata & laneMask; lastWe = obsWe;
        end
        ack = (busCnt == ackAt);
        err = errIn;
        rdata = ack ? rdataIn : {$urandom, $urandom};
      end
      if (obsRspValid) begin
        gotRsp = 1'b1;
        checkOutput("rsp_exc", 64'(obsExc), 64'(expExc));
        checkOutput("rsp_wreg", 64'(obsWreg), 64'(isLoad && expExc == 3'd0));
        checkOutput("rsp_wdata", obsRspData, expData);
        checkOutput("rsp_wd", 64'(obsRspWd), 64'(wdIn));
        checkOutput("rsp_cycle", 64'(cyc), 64'(expRsp));
        lastRspData = obsRspData; lastWreg = obsWreg; lastExc = obsExc; lastRspCycle = cyc;
      end
      @(negedge clk);
      ack = 1'b0; err = 1'b0;
      cyc++;
    end
    checkOutput("rsp_seen", 64'(gotRsp), 64'd1);
    checkOutput("bus_cycles", 64'(busCnt), 64'(expBus));
    checkOutput("stall_cycles", 64'(stallCnt), 64'(expRsp));
    checkOutput("rsp_one_pulse", 64'(obsRspValid), 64'd0);
    checkOutput("ready_after", 64'(obsReady), 64'd1);
    lastBusCycles = busCnt; lastStall = stallCnt;
  endtask

  task automatic checkResetState(input int dutSel);
    which = dutSel;
    #1;
    checkOutput("rst_ready", 64'(obsReady), 64'd1);
    checkOutput("rst_bus_req", 64'(obsBusReq), 64'd0);
    checkOutput("rst_bus_we", 64'(obsWe), 64'd0);
    checkOutput("rst_bus_addr", obsBusAddr, 64'd0);
    checkOutput("rst_bus_sel", obsSel, 64'd0);
    checkOutput("rst_bus_wdata", obsBusWdata, 64'd0);
    checkOutput("rst_rsp_valid", 64'(obsRspValid), 64'd0);
    checkOutput("rst_rsp", {obsRspData[58:0], obsRspWd}, 64'd0);
    checkOutput("rst_wreg_exc", {60'd0, obsWreg, obsExc}, 64'd0);
    checkOutput("rst_stall", 64'(obsStall), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ds, tmo, ackAt;
    logic [3:0] rop;
    logic [31:0] raddr;
    rst = 1'b1; reqValid = 1'b0; op = '0; addr = '0; wdata = '0; wd = '0;
    ack = 1'b0; err = 1'b0; rdata = '0; which = 0;
    repeat (3) @(negedge clk);
    checkResetState(0);
    checkResetState(1);
    rst = 1'b0;

    $display("[TB] directed accesses");
    applyStimulus(0, 4'h0, 32'h1001, 64'd0, 5'd3, 1, 1'b0, 64'h1182_3344);
    checkOutput("lb_sel", lastSel, 64'h4);
    checkOutput("lb_bus_addr", lastBusAddr, 64'h1000);
    checkOutput("lb_data", lastRspData, 64'hFFFF_FF82);
    checkOutput("lb_wreg", 64'(lastWreg), 64'd1);
    checkOutput("lb_latency", 64'(lastRspCycle), 64'd2);

    applyStimulus(0, 4'h9, 32'h2002, 64'h0000_ABCD, 5'd7, 3, 1'b0, 64'd0);
    checkOutput("sh_sel", lastSel, 64'h3);
    checkOutput("sh_wdata", lastWdata & 64'hFFFF, 64'hABCD);
    checkOutput("sh_we", 64'(lastWe), 64'd1);
    checkOutput("sh_wreg_exc", {60'd0, lastWreg, lastExc}, 64'd0);
    checkOutput("sh_stall", 64'(lastStall), 64'd4);

    applyStimulus(0, 4'h4, 32'h3002, 64'd0, 5'd9, 1, 1'b0, 64'd0);
    checkOutput("lw_mis_exc", 64'(lastExc), 64'd1);
    checkOutput("lw_mis_nobus", 64'(lastBusCycles), 64'd0);

    applyStimulus(0, 4'h6, 32'h3000, 64'd0, 5'd10, 1, 1'b0, 64'd0);
    checkOutput("ld32_exc", 64'(lastExc), 64'd5);
    checkOutput("ld32_nobus", 64'(lastBusCycles), 64'd0);

    applyStimulus(0, 4'h3, 32'h3006, 64'd0, 5'd11, 0, 1'b0, 64'd0);
    checkOutput("tmo_bus_cycles", 64'(lastBusCycles), 64'd4);
    checkOutput("tmo_exc", 64'(lastExc), 64'd4);
    checkOutput("tmo_wreg", 64'(lastWreg), 64'd0);

    applyStimulus(0, 4'h2, 32'h3006, 64'd0, 5'd12, 4, 1'b0, 64'h0000_8001);
    checkOutput("ack_at_terminal_exc", 64'(lastExc), 64'd0);

    applyStimulus(0, 4'h4, 32'h3008, 64'd0, 5'd13, 2, 1'b1, 64'h1234_5678);
    checkOutput("bus_err_exc", 64'(lastExc), 64'd3);

    applyStimulus(1, 4'h5, 32'h5004, 64'd0, 5'd14, 2, 1'b0, 64'h0123_4567_89AB_CDEF);
    checkOutput("lwu64_data", lastRspData, 64'h0000_0000_89AB_CDEF);

    applyStimulus(1, 4'hB, 32'h6008, 64'h1122_3344_5566_7788, 5'd15, 1, 1'b0, 64'd0);
    checkOutput("sd64_sel", lastSel, 64'hFF);

    $display("[TB] reset during bus phase");
    @(negedge clk);
    which = 0; op = 4'h4; addr = 32'h4000; wd = 5'd1; reqValid = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("pre_rst_bus_req", 64'(obsBusReq), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_drop_bus_req", 64'(obsBusReq), 64'd0);
    checkOutput("rst_drop_ready", 64'(obsReady), 64'd1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("rst_no_rsp", 64'(obsRspValid), 64'd0);
    end
    rst = 1'b0;
    applyStimulus(0, 4'h1, 32'h4003, 64'd0, 5'd2, 2, 1'b0, 64'h0000_00F0);
    checkOutput("post_rst_lbu", lastRspData, 64'hF0);

    $display("[TB] random accesses");
    for (int n = 0; n < 60; n++) begin
      ds = int'($urandom_range(0, 1));
      tmo = (ds == 1) ? 15 : 4;
      rop = 4'($urandom_range(0, 15));
      raddr = $urandom;
      if ($urandom_range(0, 2) != 0) raddr[2:0] = 3'd0;
      if ($urandom_range(0, 3) == 0) raddr[2:0] = 3'd4;
      ackAt = int'($urandom_range(1, tmo + 1));
      applyStimulus(ds, rop, raddr, {$urandom, $urandom}, 5'($urandom), ackAt,
                    $urandom_range(0, 3) == 0, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
